if_id_pipe_reg: RTL and testbench

IF/ID pipeline register. It consumes the IF_ID_sync_nop flush request and the load-use stall request, and turns them into bubbles or held state in the decode stage. It sits between instruction fetch and decode in the 16-bit pipeline. Instruction memory output is synchronous, so the block holds a one-entry replay buffer that keeps a fetched instruction across a stall. It also keeps saturating flush and stall event counters for performance debug.

---
 rtl/if_id_pipe_reg_pkg.sv | 19 +
 rtl/if_id_pipe_reg_if.sv | 26 ++
 rtl/if_id_pipe_reg_sat_counter.sv | 31 +++
 rtl/if_id_pipe_reg.sv | 115 +++++++++++
 tb/tb_if_id_pipe_reg.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/if_id_pipe_reg_pkg.sv
// Shared types and constants for the IF/ID pipeline register.
// State codes and the bubble encoding live here so every file agrees on them.
package if_id_pipe_reg_pkg;

    localparam int          IFID_WIDTH     = 16;
    localparam int          IFID_CNT_WIDTH = 16;
    localparam logic [15:0] NOP            = 16'h0000;

    // 2-bit encoding; the unused codes are treated as RUN.
    typedef enum logic [1:0] {
        IFID_RUN   = 2'b00,
        IFID_STALL = 2'b01
    } ifid_state_e;

    function automatic logic is_stall_state(input ifid_state_e code);
        return code == IFID_STALL;
    endfunction

endpackage

// File: rtl/if_id_pipe_reg_if.sv
// Fetch-to-decode bus. The master is the pipeline side (fetch, hazard unit,
// decode); the slave is the IF/ID register itself.
interface if_id_pipe_reg_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] IF_instr;
    logic [WIDTH-1:0] IF_pc_plus1;
    logic             IF_ID_sync_nop;
    logic             hazard_stall;
    logic             pc_write_en;
    logic [WIDTH-1:0] ID_instr;
    logic [WIDTH-1:0] ID_pc_plus1;
    logic             ID_valid;

    // No valid/ready pairing: IF_instr is valid every cycle, hazard_stall
    // back-pressures fetch via pc_write_en, and ID_valid=0 marks a bubble.
    modport master (
        output IF_instr, IF_pc_plus1, IF_ID_sync_nop, hazard_stall,
        input  pc_write_en, ID_instr, ID_pc_plus1, ID_valid
    );

    modport slave (
        input  IF_instr, IF_pc_plus1, IF_ID_sync_nop, hazard_stall,
        output pc_write_en, ID_instr, ID_pc_plus1, ID_valid
    );
endinterface

// File: rtl/if_id_pipe_reg_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: turns flush and load-use stall requests into
// bubbles or held decode state, with a one-entry replay buffer for stalls.
module if_id_pipe_reg
    import if_id_pipe_reg_pkg::*;
#(
    parameter int               WIDTH     = IFID_WIDTH,
    parameter int               CNT_WIDTH = IFID_CNT_WIDTH,
    parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(NOP)
) (
    input  logic                 clk,
    input  logic                 rst,
    if_id_pipe_reg_if.slave      bus,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [CNT_WIDTH-1:0] stall_count,
    output ifid_state_e          state_dbg,
    output logic                 replay_valid_dbg
);

    ifid_state_e      state_q, state_d;
    logic [WIDTH-1:0] id_instr_q, id_instr_d;
    logic [WIDTH-1:0] id_pc_plus1_q, id_pc_plus1_d;
    logic             id_valid_q, id_valid_d;
    logic [WIDTH-1:0] replay_instr_q, replay_instr_d;
    logic [WIDTH-1:0] replay_pc_q, replay_pc_d;
    logic             replay_valid_q, replay_valid_d;
    logic             flush_inc;
    logic             stall_inc;
    logic             in_stall;

    assign in_stall = is_stall_state(state_q);

    always_comb begin
        state_d        = in_stall ? IFID_STALL : IFID_RUN;
        id_instr_d     = id_instr_q;
        id_pc_plus1_d  = id_pc_plus1_q;
        id_valid_d     = id_valid_q;
        replay_instr_d = replay_instr_q;
        replay_pc_d    = replay_pc_q;
        replay_valid_d = replay_valid_q;
        flush_inc      = 1'b0;
        stall_inc      = 1'b0;

        if (bus.IF_ID_sync_nop) begin
            // Anything buffered is on the wrong path, so it is dropped.
            id_instr_d     = NOP_INSTR;
            id_valid_d     = 1'b0;
            replay_valid_d = 1'b0;
            state_d        = IFID_RUN;
            flush_inc      = 1'b1;
        end else if (bus.hazard_stall) begin
            stall_inc = 1'b1;
            if (!in_stall) begin
                replay_instr_d = bus.IF_instr;
                replay_pc_d    = bus.IF_pc_plus1;
                replay_valid_d = 1'b1;
                state_d        = IFID_STALL;
            end
        end else if (in_stall) begin
            // The PC was frozen, so IF is re-presenting what we already hold.
            id_instr_d     = replay_instr_q;
            id_pc_plus1_d  = replay_pc_q;
            id_valid_d     = 1'b1;
            replay_valid_d = 1'b0;
            state_d        = IFID_RUN;
        end else begin
            id_instr_d    = bus.IF_instr;
            id_pc_plus1_d = bus.IF_pc_plus1;
            id_valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IFID_RUN;
            id_instr_q     <= NOP_INSTR;
            id_pc_plus1_q  <= '0;
            id_valid_q     <= 1'b0;
            replay_instr_q <= '0;
            replay_pc_q    <= '0;
            replay_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            id_instr_q     <= id_instr_d;
            id_pc_plus1_q  <= id_pc_plus1_d;
            id_valid_q     <= id_valid_d;
            replay_instr_q <= replay_instr_d;
            replay_pc_q    <= replay_pc_d;
            replay_valid_q <= replay_valid_d;
        end
    end

    // A flush must always let the PC move to the branch target.
    assign bus.pc_write_en = ~bus.hazard_stall | bus.IF_ID_sync_nop;
    assign bus.ID_instr    = id_instr_q;
    assign bus.ID_pc_plus1 = id_pc_plus1_q;
    assign bus.ID_valid    = id_valid_q;

    assign state_dbg        = state_q;
    assign replay_valid_dbg = replay_valid_q;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_count)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_count)
    );

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for if_id_pipe_reg: directed scenarios then random traffic, all
// checked against a queue-based model of the decode-stage contents.
module tb_if_id_pipe_reg;
    import if_id_pipe_reg_pkg::*;

    localparam int W  = 16;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk;
    logic rst;
    logic [CW-1:0] flush_count;
    logic [CW-1:0] stall_count;
    ifid_state_e   state_dbg;
    logic          replay_valid_dbg;

    if_id_pipe_reg_if #(.WIDTH(W)) bus ();

    if_id_pipe_reg #(.WIDTH(W), .CNT_WIDTH(CW), .NOP_INSTR(16'h0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .flush_count      (flush_count),
        .stall_count      (stall_count),
        .state_dbg        (state_dbg),
        .replay_valid_dbg (replay_valid_dbg)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state
    int errors = 0;
    int checks = 0;
    logic [W-1:0]   m_instr;
    logic [W-1:0]   m_pc;
    logic           m_valid;
    int             m_flush;
    int             m_stall;
    logic [2*W-1:0] held_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_instr = 16'h0000;
        m_pc    = '0;
        m_valid = 1'b0;
        m_flush = 0;
        m_stall = 0;
        held_q.delete();
    endtask

    // Decode-stage behaviour described as "bubble, hold-and-remember, or take
    // the oldest remembered/incoming instruction".
    task automatic model_edge(input logic [W-1:0] instr, input logic [W-1:0] pc,
                              input logic nop, input logic stall);
        logic [2*W-1:0] e;
        if (nop) begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
            held_q.delete();
            if (m_flush < CNT_MAX) m_flush++;
        end else if (stall) begin
            if (held_q.size() == 0) held_q.push_back({instr, pc});
            if (m_stall < CNT_MAX) m_stall++;
        end else if (held_q.size() != 0) begin
            e = held_q.pop_front();
            m_instr = e[2*W-1:W];
            m_pc    = e[W-1:0];
            m_valid = 1'b1;
        end else begin
            m_instr = instr;
            m_pc    = pc;
            m_valid = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".instr"}, 32'(bus.ID_instr), 32'(m_instr));
        check({tag, ".pc"},    32'(bus.ID_pc_plus1), 32'(m_pc));
        check({tag, ".valid"}, 32'(bus.ID_valid), 32'(m_valid));
        check({tag, ".flush"}, 32'(flush_count), 32'(m_flush));
        check({tag, ".stall"}, 32'(stall_count), 32'(m_stall));
        check({tag, ".state"}, 32'(state_dbg), (held_q.size() != 0) ? 32'(IFID_STALL) : 32'(IFID_RUN));
        check({tag, ".rvalid"}, 32'(replay_valid_dbg), 32'(held_q.size() != 0));
    endtask

    // driver: called shortly after a rising edge, returns 1 time unit after the next one
    task automatic drive_cycle(input string tag, input logic [W-1:0] instr,
                               input logic [W-1:0] pc, input logic nop, input logic stall);
        bus.IF_instr       = instr;
        bus.IF_pc_plus1    = pc;
        bus.IF_ID_sync_nop = nop;
        bus.hazard_stall   = stall;
        #1;
        check({tag, ".pcwe"}, 32'(bus.pc_write_en), 32'(!stall || nop));
        @(posedge clk);
        model_edge(instr, pc, nop, stall);
        #1;
        check_outputs(tag);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_outputs(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.IF_instr       = '0;
        bus.IF_pc_plus1    = '0;
        bus.IF_ID_sync_nop = 1'b0;
        bus.hazard_stall   = 1'b0;
        model_reset();
        #1;
        check_outputs("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // normal flow, one-cycle latency
        drive_cycle("norm0", 16'hA001, 16'h0101, 1'b0, 1'b0);
        drive_cycle("norm1", 16'hA002, 16'h0102, 1'b0, 1'b0);
        drive_cycle("norm2", 16'hA003, 16'h0103, 1'b0, 1'b0);

        // two-cycle stall, replay on release even though IF shows FFFF
        drive_cycle("stl0", 16'hB005, 16'h0105, 1'b0, 1'b1);
        drive_cycle("stl1", 16'hB005, 16'h0105, 1'b0, 1'b1);
        check("stl.hold", 32'(bus.ID_instr), 32'h0000A003);
        drive_cycle("stlrel", 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
        check("stl.replay", 32'(bus.ID_instr), 32'h0000B005);
        check("stl.count", 32'(stall_count), 32'd2);

        // two-cycle flush
        drive_cycle("fl0", 16'hD001, 16'h0201, 1'b1, 1'b0);
        drive_cycle("fl1", 16'hD002, 16'h0202, 1'b1, 1'b0);
        check("fl.count", 32'(flush_count), 32'd2);

        // flush while stalled: buffered C00C must never reach decode
        drive_cycle("fs0", 16'hE001, 16'h0301, 1'b0, 1'b0);
        drive_cycle("fs1", 16'hC00C, 16'h030C, 1'b0, 1'b1);
        drive_cycle("fs2", 16'hC00C, 16'h030C, 1'b1, 1'b1);
        check("fs.bubble", 32'(bus.ID_valid), 32'd0);
        drive_cycle("fs3", 16'hE002, 16'h0302, 1'b0, 1'b0);
        check("fs.noreplay", 32'(bus.ID_instr), 32'h0000E002);

        // reset while stalled discards the buffer; first edge after takes IF
        drive_cycle("rs0", 16'hC0DE, 16'h0400, 1'b0, 1'b1);
        async_reset("rsmid");
        drive_cycle("rs1", 16'h1234, 16'h0401, 1'b0, 1'b0);
        check("rs.first", 32'(bus.ID_instr), 32'h00001234);

        // saturation of the 4-bit flush counter
        for (int i = 0; i < 20; i++) begin
            drive_cycle("sat", 16'(i), 16'(i), 1'b1, 1'b0);
        end
        check("sat.flush", 32'(flush_count), 32'h0000000F);
        drive_cycle("sat2", 16'h5555, 16'h0555, 1'b1, 1'b0);
        check("sat.stay", 32'(flush_count), 32'h0000000F);

        // random traffic with an occasional async reset
        for (int i = 0; i < 400; i++) begin
            if (i % 97 == 50) async_reset("rnd_rst");
            drive_cycle("rnd", 16'($urandom), 16'($urandom),
                        ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
